// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane store merge and load extension for one 32-bit word.
// DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors.
module dmem_lane_fmt
  import mem_pkg::*;
(
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic [1:0]            off,
  input  logic                  uns,
  input  logic [31:0]           wdata,
  input  logic [31:0]           old,
  output logic [31:0]           wword,
  output logic [WORD_BYTES-1:0] be,
  output logic [31:0]           rdata,
  output logic                  err
);

  logic [31:0] lanes;
  logic [31:0] ld;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        misal;

  always_comb begin
    be    = '0;
    lanes = '0;
    ld    = '0;
    err   = 1'b0;
    misal = 1'b0;
    wword = old;
    bsel  = old[{off, 3'b000} +: 8];
    hsel  = old[{off[1], 4'b0000} +: 16];
`ifdef DMEM_MISALIGN_ERR_EN
    misal = ((size == MEM_H) && off[0]) ||
            ((size == MEM_W) && (off != 2'b00));
`endif
    unique case (1'b1)
      size == MEM_B: begin
        be    = 4'b0001 << off;
        lanes = {4{wdata[7:0]}};
        ld    = uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      end
      size == MEM_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        lanes = {2{wdata[15:0]}};
        ld    = uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      end
      size == MEM_W: begin
        be    = 4'b1111;
        lanes = wdata;
        ld    = old;
      end
      default: err = 1'b1;
    endcase
    if (misal)
      err = 1'b1;
    if (err || !we)
      be = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      if (be[i])
        wword[8*i +: 8] = lanes[8*i +: 8];
    rdata = (we || err) ? 32'b0 : ld;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, wait states, valid/ready response out.
// Optional DMEM_MISALIGN_ERR_EN faults misaligned half/word accesses.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  dmem_state_t state;
  logic [3:0]  cnt;

  logic        c_we;
  logic [IW+1:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_size;
  logic        c_uns;

  logic        cur_we;
  logic [IW+1:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_uns;

  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [31:0] old;
  logic [31:0] wword;
  logic [WORD_BYTES-1:0] be;
  logic [31:0] fmt_rdata;
  logic        fmt_err;
  logic        accept;
  logic        commit;
  logic        unused;

  assign unused    = ^req_addr[ADDR_W-1:IW+2];
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Zero-wait builds commit on the accept edge, so use the live inputs.
  assign cur_we    = (state == IDLE) ? req_we : c_we;
  assign cur_addr  = (state == IDLE) ? req_addr[IW+1:0] : c_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : c_wdata;
  assign cur_size  = (state == IDLE) ? req_size : c_size;
  assign cur_uns   = (state == IDLE) ? req_unsigned : c_uns;

  assign idx = cur_addr[IW+1:2];
  assign old = mem[idx];

  assign commit = (accept && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd0));

  dmem_lane_fmt u_fmt (
    .we    (cur_we),
    .size  (cur_size),
    .off   (cur_addr[1:0]),
    .uns   (cur_uns),
    .wdata (cur_wdata),
    .old   (old),
    .wword (wword),
    .be    (be),
    .rdata (fmt_rdata),
    .err   (fmt_err)
  );

  always_ff @(posedge clk) begin
    if (!reset && commit && (be != '0))
      mem[idx] <= wword;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      c_we      <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= 32'b0;
      c_size    <= 2'b00;
      c_uns     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            c_we    <= req_we;
            c_addr  <= req_addr[IW+1:0];
            c_wdata <= req_wdata;
            c_size  <= req_size;
            c_uns   <= req_unsigned;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= fmt_rdata;
              rsp_err   <= fmt_err;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= fmt_rdata;
            rsp_err   <= fmt_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a behavioural memory model.
// Honours DMEM_MISALIGN_ERR_EN for its expectations.
module tb_dmem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_we = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        req_unsigned = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .ADDR_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];

  typedef enum {M_IDLE, M_PEND, M_RESP} mphase_t;
  mphase_t     ph = M_IDLE;
  int          left;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [1:0]  p_size;
  logic        p_uns;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          exp_unk;
  int          cyc = 0, acc_cyc = 0, val_cyc = 0, hs_cyc = 0;
  bit          want_val = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  function automatic void access(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic uns, output logic [31:0] rd,
                                 output logic er, output bit unk);
    int idx = int'((addr >> 2) % DEPTH);
    int off = int'(addr % 4);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int k = 0; k < 4; k++) b[k] = mdl[idx][8*k +: 8];
    rd  = 0;
    unk = 0;
    er  = (size == 2'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    if (size == 2'd1 && (off % 2) != 0) er = 1;
    if (size == 2'd2 && off != 0) er = 1;
`endif
    if (er) return;
    if (size == 2'd1) off = off & 2;
    if (size == 2'd2) off = 0;
    if (we) begin
      case (size)
        2'd0: b[off] = wdata[7:0];
        2'd1: begin b[off] = wdata[7:0]; b[off+1] = wdata[15:8]; end
        default: for (int k = 0; k < 4; k++) b[k] = wdata[8*k +: 8];
      endcase
      mdl[idx] = {b[3], b[2], b[1], b[0]};
      if (size == 2'd2) known[idx] = 1;
    end else begin
      unk = !known[idx];
      case (size)
        2'd0: rd = uns ? 32'(b[off]) : 32'($signed(b[off]));
        2'd1: begin
          h  = {b[off+1], b[off]};
          rd = uns ? 32'(h) : 32'($signed(h));
        end
        default: rd = {b[3], b[2], b[1], b[0]};
      endcase
    end
  endfunction

  task automatic commit();
    access(p_we, p_addr, p_wdata, p_size, p_uns, exp_rdata, exp_err, exp_unk);
    ph = M_RESP;
  endtask

  // compare process: check outputs, then predict the next edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      chk("req_ready", 32'(req_ready), 32'(ph == M_IDLE && !reset));
      chk("rsp_valid", 32'(rsp_valid), 32'(ph == M_RESP));
      if (ph == M_RESP && rsp_valid === 1'b1) begin
        if (!exp_unk) chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (want_val) begin val_cyc = cyc; want_val = 0; end
      end
      if (reset) begin
        ph = M_IDLE;
      end else begin
        case (ph)
          M_IDLE: if (req_valid) begin
            p_we = req_we; p_addr = req_addr; p_wdata = req_wdata;
            p_size = req_size; p_uns = req_unsigned;
            acc_cyc = cyc; want_val = 1;
            if (WS == 0) commit();
            else begin left = WS; ph = M_PEND; end
          end
          M_PEND: begin
            left--;
            if (left == 0) commit();
          end
          M_RESP: if (rsp_ready) begin
            last_rdata = exp_rdata; last_err = exp_err;
            hs_cyc = cyc; ph = M_IDLE;
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  int bp = 0;
  int hold = 0;

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = (hold > 0) ? 1'b0 : (($urandom % 100) >= bp);
    if (hold > 0) hold--;
  end

  task automatic present(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic u);
    req_valid = 1; req_we = we; req_addr = addr;
    req_wdata = wd; req_size = sz; req_unsigned = u;
  endtask

  task automatic wait_accept();
    bit acc = 0;
    int n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    req_valid = 0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  task automatic wait_rsp();
    bit hs = 0;
    int n = 0;
    while (!hs && n < 200) begin
      @(negedge clk); hs = rsp_valid && rsp_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) chk("rsp_timeout", 0, 1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] sz,
                     input logic u);
    present(we, addr, wd, sz, u);
    wait_accept();
    wait_rsp();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    reset = 0;

    for (int i = 0; i < 64; i++) txn(1, 32'(i * 4), $urandom, 2'd2, 0);

    // word store/load and latency
    txn(1, 32'h10, 32'hDEADBEEF, 2'd2, 0);
    chk("lat_store", 32'(val_cyc - acc_cyc), 32'(WS + 1));
    chk("sw_err", 32'(last_err), 0);
    txn(0, 32'h10, 0, 2'd2, 0);
    chk("lw_10", last_rdata, 32'hDEADBEEF);

    // byte/half merge and extension
    txn(1, 32'h20, 32'h0, 2'd2, 0);
    txn(1, 32'h23, 32'hFFFFFF80, 2'd0, 0);
    txn(1, 32'h20, 32'hABCD1234, 2'd1, 0);
    txn(0, 32'h20, 0, 2'd2, 0);
    chk("lw_merge", last_rdata, 32'h80001234);
    txn(0, 32'h23, 0, 2'd0, 0);
    chk("lb_23", last_rdata, 32'hFFFFFF80);
    txn(0, 32'h23, 0, 2'd0, 1);
    chk("lbu_23", last_rdata, 32'h00000080);
    txn(0, 32'h20, 0, 2'd1, 0);
    chk("lh_20", last_rdata, 32'h00001234);

    // backpressure with a queued request
    present(1, 32'h30, 32'h5A5A0FF0, 2'd2, 0);
    wait_accept();
    hold = 8;
    present(0, 32'h30, 0, 2'd2, 0);
    wait_rsp();
    wait_accept();
    chk("next_accept", 32'(acc_cyc - hs_cyc), 1);
    wait_rsp();
    chk("lw_30", last_rdata, 32'h5A5A0FF0);

    // wrap and reserved size
    txn(1, 32'h1000, 32'hA5A5A5A5, 2'd2, 0);
    txn(0, 32'h0, 0, 2'd2, 0);
    chk("wrap", last_rdata, 32'hA5A5A5A5);
    txn(1, 32'h10, 32'h0, 2'd3, 0);
    chk("rsv_err", 32'(last_err), 1);
    txn(0, 32'h10, 0, 2'd2, 0);
    chk("rsv_nowrite", last_rdata, 32'hDEADBEEF);

    // reset mid-operation
    txn(1, 32'h40, 32'h22222222, 2'd2, 0);
    present(1, 32'h40, 32'h11111111, 2'd2, 0);
    wait_accept();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_err", 32'(rsp_err), 0);
    chk("midrst_rdata", rsp_rdata, 0);
    reset = 0;
    txn(0, 32'h40, 0, 2'd2, 0);
    chk("midrst_mem", last_rdata, 32'h22222222);

    // misaligned word load
    txn(0, 32'h42, 0, 2'd2, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("mis_err", 32'(last_err), 1);
    chk("mis_rdata", last_rdata, 0);
`else
    chk("mis_err", 32'(last_err), 0);
    chk("mis_rdata", last_rdata, 32'h22222222);
`endif

    // randomized traffic with backpressure
    bp = 40;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom << 12) | 32'(($urandom % 64) << 2) | ($urandom % 4);
      sz = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
      txn(1'($urandom), a, $urandom, sz, 1'($urandom));
    end
    bp = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
